// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared scan-code constants, move encodings and state types
// Optional feature macro: KB_KEYPAD_EN (numeric keypad digits in digit_of).
package kb_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_O     = 8'h44;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_9     = 8'h46;

    localparam logic [1:0] MV_NONE = 2'b00;
    localparam logic [1:0] MV_X    = 2'b01;
    localparam logic [1:0] MV_O    = 2'b10;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_POS_HI,
        ST_POS_LO,
        ST_MOV_HI,
        ST_MOV_LO
    } seq_state_t;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_BREAK,
        DEC_EXT
    } dec_state_t;

    // Cell number for a digit make code, 0 when the code is not a digit.
    function automatic logic [3:0] digit_of(input logic [7:0] code);
        logic [3:0] d;
        case (code)
            SC_1:  d = 4'd1;
            SC_2:  d = 4'd2;
            SC_3:  d = 4'd3;
            SC_4:  d = 4'd4;
            SC_5:  d = 4'd5;
            SC_6:  d = 4'd6;
            SC_7:  d = 4'd7;
            SC_8:  d = 4'd8;
            SC_9:  d = 4'd9;
`ifdef KB_KEYPAD_EN
            8'h69: d = 4'd1;
            8'h72: d = 4'd2;
            8'h7A: d = 4'd3;
            8'h6B: d = 4'd4;
            8'h73: d = 4'd5;
            8'h74: d = 4'd6;
            8'h6C: d = 4'd7;
            8'h75: d = 4'd8;
            8'h7D: d = 4'd9;
`endif
            default: d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/kb_make_decoder.sv
// rtl/kb_make_decoder.sv - PS/2 set-2 prefix tracker and make-code lookup
// Optional feature macro: KB_KEYPAD_EN (E0 5A keypad Enter acts as Enter).
// Ports: clock, reset (async high); scan_code/scan_code_ready in;
//        one-cycle strobes digit_vld/digit, x_vld, o_vld, bksp_vld, enter_vld out
//        (combinational, same cycle as scan_code_ready).
module kb_make_decoder
    import kb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_code_ready,
    output logic       digit_vld,
    output logic [3:0] digit,
    output logic       x_vld,
    output logic       o_vld,
    output logic       bksp_vld,
    output logic       enter_vld
);

    dec_state_t state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= DEC_NORMAL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        digit_vld = 1'b0;
        digit     = 4'd0;
        x_vld     = 1'b0;
        o_vld     = 1'b0;
        bksp_vld  = 1'b0;
        enter_vld = 1'b0;
        if (scan_code_ready) begin
            case (state_q)
                DEC_NORMAL: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = DEC_BREAK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = DEC_EXT;
                    end else begin
                        digit     = digit_of(scan_code);
                        digit_vld = (digit != 4'd0);
                        x_vld     = (scan_code == SC_X);
                        o_vld     = (scan_code == SC_O);
                        bksp_vld  = (scan_code == SC_BKSP);
                        enter_vld = (scan_code == SC_ENTER);
                    end
                end
                // The released key's code carries no information.
                DEC_BREAK: state_d = DEC_NORMAL;
                DEC_EXT: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = DEC_BREAK;
                    end else begin
                        state_d = DEC_NORMAL;
`ifdef KB_KEYPAD_EN
                        enter_vld = (scan_code == SC_ENTER);
`endif
                    end
                end
                default: state_d = DEC_NORMAL;
            endcase
        end
    end

endmodule

// File: rtl/kb_move_sequencer.sv
// rtl/kb_move_sequencer.sv - keyboard move entry and timed go-strobe replay
// Optional feature macro: KB_KEYPAD_EN (keypad digits and keypad Enter).
// Ports: clock, reset (async high); scan_code, scan_code_ready in;
//        move, pos, go, busy to control/datapath; pend_pos, pend_move for
//        display; reject pulses one cycle when Enter is refused.
module kb_move_sequencer
    import kb_pkg::*;
#(
    parameter int GO_HOLD = 4,
    parameter int GO_GAP  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_code_ready,
    output logic [1:0] move,
    output logic [3:0] pos,
    output logic       go,
    output logic       busy,
    output logic [3:0] pend_pos,
    output logic [1:0] pend_move,
    output logic       reject
);

    localparam int CMAX = (GO_HOLD > GO_GAP) ? GO_HOLD : GO_GAP;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(GO_HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GO_GAP - 1);

    logic       digit_vld, x_vld, o_vld, bksp_vld, enter_vld;
    logic [3:0] digit;

    kb_make_decoder u_dec (
        .clock           (clock),
        .reset           (reset),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .digit_vld       (digit_vld),
        .digit           (digit),
        .x_vld           (x_vld),
        .o_vld           (o_vld),
        .bksp_vld        (bksp_vld),
        .enter_vld       (enter_vld)
    );

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pend_pos_d, pos_d;
    logic [1:0]    pend_move_d, move_d;
    logic          go_d, busy_d, reject_d;
    logic          last;

    // Counter is loaded with length-1 on entry; the phase ends when it hits 0.
    assign last = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_pos_d  = pend_pos;
        pend_move_d = pend_move;
        reject_d    = 1'b0;
        if (state_q != ST_COLLECT) cnt_d = cnt_q - CW'(1);
        case (state_q)
            ST_COLLECT: begin
                // Only this state accepts edits; replay ignores make codes.
                if (digit_vld) pend_pos_d = digit;
                if (x_vld)     pend_move_d = MV_X;
                if (o_vld)     pend_move_d = MV_O;
                if (bksp_vld) begin
                    if (pend_move != MV_NONE) pend_move_d = MV_NONE;
                    else                      pend_pos_d  = 4'd0;
                end
                if (enter_vld) begin
                    if (pend_pos != 4'd0 && pend_move != MV_NONE) begin
                        state_d = ST_POS_HI;
                        cnt_d   = HOLD_LD;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_POS_HI: if (last) begin state_d = ST_POS_LO; cnt_d = GAP_LD;  end
            ST_POS_LO: if (last) begin state_d = ST_MOV_HI; cnt_d = HOLD_LD; end
            ST_MOV_HI: if (last) begin state_d = ST_MOV_LO; cnt_d = GAP_LD;  end
            ST_MOV_LO: if (last) begin
                state_d     = ST_COLLECT;
                cnt_d       = '0;
                pend_pos_d  = 4'd0;
                pend_move_d = MV_NONE;
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so go rises the cycle after Enter.
    always_comb begin
        go_d   = (state_d == ST_POS_HI) || (state_d == ST_MOV_HI);
        busy_d = (state_d != ST_COLLECT);
        pos_d  = busy_d ? pend_pos : 4'd0;
        move_d = ((state_d == ST_MOV_HI) || (state_d == ST_MOV_LO)) ? pend_move : MV_NONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            pend_pos  <= 4'd0;
            pend_move <= MV_NONE;
            reject    <= 1'b0;
            go        <= 1'b0;
            busy      <= 1'b0;
            pos       <= 4'd0;
            move      <= MV_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_pos  <= pend_pos_d;
            pend_move <= pend_move_d;
            reject    <= reject_d;
            go        <= go_d;
            busy      <= busy_d;
            pos       <= pos_d;
            move      <= move_d;
        end
    end

endmodule

// File: tb/tb_kb_move_sequencer.sv
// tb/tb_kb_move_sequencer.sv - self-checking bench for kb_move_sequencer
module tb_kb_move_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic [1:0] move;
    logic [3:0] pos;
    logic       go;
    logic       busy;
    logic [3:0] pend_pos;
    logic [1:0] pend_move;
    logic       reject;

    int errors = 0;
    int checks = 0;
    int go_rises = 0;
    logic go_prev = 1'b0;

    typedef struct packed {
        logic       go;
        logic [3:0] pos;
        logic [1:0] move;
        logic       busy;
        logic [3:0] pp;
        logic [1:0] pm;
    } obs_t;

    obs_t exp_q[$];

    kb_move_sequencer #(.GO_HOLD(4), .GO_GAP(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .move            (move),
        .pos             (pos),
        .go              (go),
        .busy            (busy),
        .pend_pos        (pend_pos),
        .pend_move       (pend_move),
        .reject          (reject)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (go && !go_prev) go_rises++;
        go_prev = go;
    end

    // Called at a negedge; returns at the next negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        scan_code       = b;
        scan_code_ready = 1'b1;
        @(negedge clock);
        scan_code_ready = 1'b0;
        scan_code       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expected per-cycle view of one replay, starting the cycle after Enter.
    task automatic push_replay(input logic [3:0] p, input logic [1:0] m);
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, p, 2'b00, 1'b1, p, m});
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, p, 2'b00, 1'b1, p, m});
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, p, m,     1'b1, p, m});
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, p, m,     1'b1, p, m});
        exp_q.push_back('{1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00});
    endtask

    task automatic drain(input string name);
        obs_t e, o;
        int idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{go, pos, move, busy, pend_pos, pend_move};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got go=%b pos=%0d move=%b busy=%b pp=%0d pm=%b, want go=%b pos=%0d move=%b busy=%b pp=%0d pm=%b",
                         name, idx, o.go, o.pos, o.move, o.busy, o.pp, o.pm,
                         e.go, e.pos, e.move, e.busy, e.pp, e.pm);
            end
            idx++;
            if (exp_q.size() > 0) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        logic r;
        o = '{go, pos, move, busy, pend_pos, pend_move};
        r = reject;
        checks++;
        if (o !== '0 || r !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h reject=%b, want 0000 reject=0", o, r);
        end
    endtask

    task automatic test_basic_replay();
        int rises0;
        send_byte(8'h2E);
        send_byte(8'hF0);
        send_byte(8'h2E);
        checks++;
        if (pend_pos !== 4'd5) begin
            errors++;
            $display("FAIL basic_pend_pos: got %0d want 5", pend_pos);
        end
        send_byte(8'h22);
        send_byte(8'hF0);
        send_byte(8'h22);
        checks++;
        if (pend_move !== 2'b01) begin
            errors++;
            $display("FAIL basic_pend_move: got %b want 01", pend_move);
        end
        rises0 = go_rises;
        push_replay(4'd5, 2'b01);
        send_byte(8'h5A);
        drain("basic_replay");
        checks++;
        if (go_rises - rises0 !== 2) begin
            errors++;
            $display("FAIL basic_go_count: got %0d want 2", go_rises - rises0);
        end
    endtask

    task automatic test_reject_no_move();
        int rises0;
        send_byte(8'h3D);
        rises0 = go_rises;
        send_byte(8'h5A);
        checks++;
        if (reject !== 1'b1) begin
            errors++;
            $display("FAIL reject_pulse: got %b want 1", reject);
        end
        @(negedge clock);
        checks++;
        if (reject !== 1'b0) begin
            errors++;
            $display("FAIL reject_one_cycle: got %b want 0", reject);
        end
        idle(6);
        checks++;
        if (go_rises !== rises0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_no_go: got rises=%0d busy=%b want rises=%0d busy=0", go_rises, busy, rises0);
        end
        checks++;
        if (pend_pos !== 4'd7) begin
            errors++;
            $display("FAIL reject_pend_pos: got %0d want 7", pend_pos);
        end
        send_byte(8'h66);
        checks++;
        if (pend_pos !== 4'd0) begin
            errors++;
            $display("FAIL reject_cleanup: got %0d want 0", pend_pos);
        end
    endtask

    task automatic test_backspace();
        send_byte(8'h46);
        send_byte(8'h44);
        checks++;
        if (pend_pos !== 4'd9 || pend_move !== 2'b10) begin
            errors++;
            $display("FAIL bksp_load: got pp=%0d pm=%b want pp=9 pm=10", pend_pos, pend_move);
        end
        send_byte(8'h66);
        checks++;
        if (pend_pos !== 4'd9 || pend_move !== 2'b00) begin
            errors++;
            $display("FAIL bksp_move: got pp=%0d pm=%b want pp=9 pm=00", pend_pos, pend_move);
        end
        send_byte(8'h66);
        checks++;
        if (pend_pos !== 4'd0 || pend_move !== 2'b00) begin
            errors++;
            $display("FAIL bksp_pos: got pp=%0d pm=%b want pp=0 pm=00", pend_pos, pend_move);
        end
        send_byte(8'h5A);
        checks++;
        if (reject !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bksp_reject: got reject=%b busy=%b want reject=1 busy=0", reject, busy);
        end
    endtask

    task automatic test_busy_ignore();
        int rises0;
        send_byte(8'h25);
        send_byte(8'h44);
        rises0 = go_rises;
        push_replay(4'd4, 2'b10);
        send_byte(8'h5A);
        fork
            drain("busy_ignore");
            begin
                send_byte(8'h16);
                send_byte(8'h5A);
            end
        join
        idle(20);
        checks++;
        if (go_rises - rises0 !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_go_count: got rises=%0d busy=%b want rises=2 busy=0", go_rises - rises0, busy);
        end
    endtask

    task automatic test_mid_reset();
        obs_t o;
        send_byte(8'h26);
        send_byte(8'h22);
        send_byte(8'h5A);
        idle(8);
        checks++;
        if (go !== 1'b1 || move !== 2'b01) begin
            errors++;
            $display("FAIL mid_in_mov_hi: got go=%b move=%b want go=1 move=01", go, move);
        end
        #3 reset = 1'b1;
        #1;
        o = '{go, pos, move, busy, pend_pos, pend_move};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: got %h want 0000", o);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        push_replay(4'd1, 2'b10);
        send_byte(8'h16);
        send_byte(8'h44);
        send_byte(8'h5A);
        drain("after_reset_replay");
    endtask

    task automatic test_keypad();
        int rises0;
        rises0 = go_rises;
        send_byte(8'h73);
        send_byte(8'h22);
        send_byte(8'hE0);
`ifdef KB_KEYPAD_EN
        push_replay(4'd5, 2'b01);
        send_byte(8'h5A);
        drain("keypad_replay");
`else
        send_byte(8'h5A);
        idle(6);
        checks++;
        if (go_rises !== rises0 || pend_pos !== 4'd0 || pend_move !== 2'b01 || reject !== 1'b0) begin
            errors++;
            $display("FAIL keypad_ignored: got rises=%0d pp=%0d pm=%b reject=%b want rises=%0d pp=0 pm=01 reject=0",
                     go_rises, pend_pos, pend_move, reject, rises0);
        end
        send_byte(8'h66);
`endif
    endtask

    initial begin
        reset           = 1'b1;
        scan_code       = 8'h00;
        scan_code_ready = 1'b0;
        idle(3);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_basic_replay();
        idle(2);
        test_reject_no_move();
        idle(2);
        test_backspace();
        idle(2);
        test_busy_ignore();
        idle(2);
        test_mid_reset();
        idle(2);
        test_keypad();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
